// File: rtl/fifo_btn_ctrl.sv
// fifo_btn_ctrl: push-button command controller in front of a synchronous FIFO.
// Turns one-cycle debounced write/read pulses into single FIFO strobes, guards
// them with the full/empty flags, captures read data for the LEDs, and keeps
// sticky overflow/underflow flags.
// Optional feature macro: FIFO_BTN_REJCNT_EN (saturating reject counter on
// rej_cnt); when undefined rej_cnt is tied to zero.
module fifo_btn_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_pulse,
    input  logic                  rd_pulse,
    input  logic                  clr_flags,
    input  logic [DATA_WIDTH-1:0] sw_data,
    input  logic                  fifo_full,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    output logic                  fifo_wr_en,
    output logic [DATA_WIDTH-1:0] fifo_wr_data,
    output logic                  fifo_rd_en,
    output logic [DATA_WIDTH-1:0] led_data,
    output logic                  led_valid,
    output logic                  ovf_flag,
    output logic                  udf_flag,
    output logic [7:0]            rej_cnt
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WRITE   = 3'd1,
        ST_READ    = 3'd2,
        ST_WAIT    = 3'd3,
        ST_CAPTURE = 3'd4
    } state_t;

    // Last WAIT count value; only meaningful when the read latency exceeds one.
    localparam logic [1:0] WAIT_LAST = (RD_LATENCY > 32'sd1) ? 2'(RD_LATENCY - 32'sd2) : 2'd0;

    state_t                  state_r, state_s;
    logic                    wr_pend_r, wr_pend_s;
    logic                    rd_pend_r, rd_pend_s;
    logic [DATA_WIDTH-1:0]   wr_hold_r, wr_hold_s;
    logic [1:0]              wait_cnt_r, wait_cnt_s;
    logic                    fifo_wr_en_r, fifo_wr_en_s;
    logic [DATA_WIDTH-1:0]   fifo_wr_data_r, fifo_wr_data_s;
    logic                    fifo_rd_en_r, fifo_rd_en_s;
    logic [DATA_WIDTH-1:0]   led_data_r, led_data_s;
    logic                    led_valid_r, led_valid_s;
    logic                    ovf_flag_r, ovf_flag_s;
    logic                    udf_flag_r, udf_flag_s;
    logic                    ovf_set_s;
    logic                    udf_set_s;

    // Next-state and next-output logic: request capture, IDLE arbitration, strobes and capture.
    always_comb begin
        state_s        = state_r;
        wr_pend_s      = wr_pend_r;
        rd_pend_s      = rd_pend_r;
        wr_hold_s      = wr_hold_r;
        wait_cnt_s     = wait_cnt_r;
        fifo_wr_en_s   = 1'b0;
        fifo_wr_data_s = fifo_wr_data_r;
        fifo_rd_en_s   = 1'b0;
        led_data_s     = led_data_r;
        led_valid_s    = led_valid_r;
        ovf_set_s      = 1'b0;
        udf_set_s      = 1'b0;

        // A pulse is only accepted when its pending bit is free; the first data wins.
        if (wr_pulse && !wr_pend_r) begin
            wr_pend_s = 1'b1;
            wr_hold_s = sw_data;
        end else begin
            wr_hold_s = wr_hold_r;
        end

        if (rd_pulse && !rd_pend_r) begin
            rd_pend_s = 1'b1;
        end else begin
            rd_pend_s = rd_pend_s;
        end

        case (state_r)
            ST_IDLE: begin
                // Write has priority; full/empty are only looked at here.
                if (wr_pend_r) begin
                    wr_pend_s = 1'b0;
                    if (!fifo_full) begin
                        state_s        = ST_WRITE;
                        fifo_wr_en_s   = 1'b1;
                        fifo_wr_data_s = wr_hold_r;
                    end else begin
                        ovf_set_s = 1'b1;
                    end
                end else if (rd_pend_r) begin
                    rd_pend_s = 1'b0;
                    if (!fifo_empty) begin
                        state_s      = ST_READ;
                        fifo_rd_en_s = 1'b1;
                    end else begin
                        udf_set_s = 1'b1;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WRITE: begin
                state_s = ST_IDLE;
            end
            ST_READ: begin
                // Zero-latency FIFOs present data during the strobe cycle itself.
                if (RD_LATENCY == 32'sd0) begin
                    led_data_s  = fifo_rd_data;
                    led_valid_s = 1'b1;
                    state_s     = ST_IDLE;
                end else if (RD_LATENCY > 32'sd1) begin
                    wait_cnt_s = 2'd0;
                    state_s    = ST_WAIT;
                end else begin
                    state_s = ST_CAPTURE;
                end
            end
            ST_WAIT: begin
                if (wait_cnt_r == WAIT_LAST) begin
                    state_s = ST_CAPTURE;
                end else begin
                    wait_cnt_s = wait_cnt_r + 2'd1;
                end
            end
            ST_CAPTURE: begin
                led_data_s  = fifo_rd_data;
                led_valid_s = 1'b1;
                state_s     = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        // Sticky flags: a new rejection beats a simultaneous clear.
        if (ovf_set_s) begin
            ovf_flag_s = 1'b1;
        end else if (clr_flags) begin
            ovf_flag_s = 1'b0;
        end else begin
            ovf_flag_s = ovf_flag_r;
        end

        if (udf_set_s) begin
            udf_flag_s = 1'b1;
        end else if (clr_flags) begin
            udf_flag_s = 1'b0;
        end else begin
            udf_flag_s = udf_flag_r;
        end
    end

    // State, pending requests and registered outputs, with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= ST_IDLE;
            wr_pend_r      <= 1'b0;
            rd_pend_r      <= 1'b0;
            wr_hold_r      <= '0;
            wait_cnt_r     <= 2'd0;
            fifo_wr_en_r   <= 1'b0;
            fifo_wr_data_r <= '0;
            fifo_rd_en_r   <= 1'b0;
            led_data_r     <= '0;
            led_valid_r    <= 1'b0;
            ovf_flag_r     <= 1'b0;
            udf_flag_r     <= 1'b0;
        end else begin
            state_r        <= state_s;
            wr_pend_r      <= wr_pend_s;
            rd_pend_r      <= rd_pend_s;
            wr_hold_r      <= wr_hold_s;
            wait_cnt_r     <= wait_cnt_s;
            fifo_wr_en_r   <= fifo_wr_en_s;
            fifo_wr_data_r <= fifo_wr_data_s;
            fifo_rd_en_r   <= fifo_rd_en_s;
            led_data_r     <= led_data_s;
            led_valid_r    <= led_valid_s;
            ovf_flag_r     <= ovf_flag_s;
            udf_flag_r     <= udf_flag_s;
        end
    end

`ifdef FIFO_BTN_REJCNT_EN
    logic [7:0] rej_cnt_r, rej_cnt_s;
    logic [2:0] rej_inc_s;
    logic [7:0] rej_base_s;
    logic [8:0] rej_sum_s;

    // Reject counter next value: clear first, then add every reject of this cycle, saturating.
    always_comb begin
        rej_inc_s  = {2'd0, wr_pulse & wr_pend_r} + {2'd0, rd_pulse & rd_pend_r}
                   + {2'd0, ovf_set_s} + {2'd0, udf_set_s};
        rej_base_s = clr_flags ? 8'd0 : rej_cnt_r;
        rej_sum_s  = {1'b0, rej_base_s} + {6'd0, rej_inc_s};
        if (rej_sum_s[8]) begin
            rej_cnt_s = 8'd255;
        end else begin
            rej_cnt_s = rej_sum_s[7:0];
        end
    end

    // Reject counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            rej_cnt_r <= 8'd0;
        end else begin
            rej_cnt_r <= rej_cnt_s;
        end
    end

    assign rej_cnt = rej_cnt_r;
`else
    assign rej_cnt = 8'd0;
`endif

    assign fifo_wr_en   = fifo_wr_en_r;
    assign fifo_wr_data = fifo_wr_data_r;
    assign fifo_rd_en   = fifo_rd_en_r;
    assign led_data     = led_data_r;
    assign led_valid    = led_valid_r;
    assign ovf_flag     = ovf_flag_r;
    assign udf_flag     = udf_flag_r;

endmodule

// File: doc/fifo_btn_ctrl.md
# fifo_btn_ctrl

Push-button command controller between the per-button debounce stages and the synchronous FIFO. It turns single-cycle debounced write/read pulses into correctly timed FIFO write and read strobes, and guards them against the FIFO's full/empty flags. Read data is captured for the LED display. Overflow and underflow attempts are recorded in sticky error flags.

## Interface
- DATA_WIDTH, 8: width of switch data, FIFO data and LED data.
- RD_LATENCY, 1: cycles from fifo_rd_en to valid fifo_rd_data. Legal range 0..3.
- clk  in  1  system clock (50 MHz board clock).
- rst  in  1  synchronous, active-high reset.
- wr_pulse  in  1  one-cycle debounced write-button pulse.
- rd_pulse  in  1  one-cycle debounced read-button pulse.
- clr_flags  in  1  one-cycle request to clear ovf_flag, udf_flag and rej_cnt.
- sw_data  in  DATA_WIDTH  slide-switch data to be written.
- fifo_full  in  1  FIFO full flag.
- fifo_empty  in  1  FIFO empty flag.
- fifo_rd_data  in  DATA_WIDTH  FIFO read data.
- fifo_wr_en  out  1  FIFO write strobe.
- fifo_wr_data  out  DATA_WIDTH  FIFO write data.
- fifo_rd_en  out  1  FIFO read strobe.
- led_data  out  DATA_WIDTH  last word read from the FIFO.
- led_valid  out  1  high once led_data holds a read word.
- ovf_flag  out  1  sticky: a write was attempted while the FIFO was full.
- udf_flag  out  1  sticky: a read was attempted while the FIFO was empty.
- rej_cnt  out  8  saturating count of rejected operations (see Configuration).

## Operation
- All outputs are registered. Reset values: every output is 0; FSM is IDLE; pending bits are cleared.
- FSM states: IDLE, WRITE, READ, WAIT, CAPTURE.
- Request capture:
  - A wr_pulse arriving in any state sets wr_pend and latches sw_data into wr_hold in the same cycle.
  - rd_pulse sets rd_pend.
  - A pulse that arrives while its own pending bit is already set is dropped and counts as rejected. The first latched data is kept.
- IDLE, wr_pend served first (write has priority):
  - If fifo_full=0: clear wr_pend and go to WRITE.
  - If fifo_full=1: clear wr_pend, set ovf_flag, count a reject, stay in IDLE.
- IDLE, rd_pend, with no wr_pend:
  - If fifo_empty=0: clear rd_pend and go to READ.
  - If fifo_empty=1: clear rd_pend, set udf_flag, count a reject.
- WRITE: fifo_wr_en=1 and fifo_wr_data=wr_hold for exactly one cycle, then IDLE.
- READ: fifo_rd_en=1 for exactly one cycle.
  - Next state is WAIT if RD_LATENCY>1, otherwise CAPTURE.
  - RD_LATENCY=0 captures in the READ cycle itself and returns directly to IDLE.
- WAIT: counts RD_LATENCY-1 cycles, then goes to CAPTURE.
- CAPTURE: led_data <= fifo_rd_data, led_valid <= 1, then IDLE.
- Full/empty are sampled only in IDLE. Flag changes during WRITE, READ or WAIT have no effect.
- clr_flags clears ovf_flag, udf_flag and rej_cnt. If a set and a clear occur in the same cycle, the set wins.
- fifo_wr_en and fifo_rd_en are never high in the same cycle, and never high for two consecutive cycles.
- Reset mid-operation discards pending requests. A write or read strobe in flight is not completed. led_valid returns to 0.

## Timing
- Write: wr_pulse in cycle k, FSM in IDLE, not full:
  - fifo_wr_en is high in cycle k+2. IDLE evaluates in cycle k+1.
  - fifo_wr_data equals sw_data as sampled in cycle k.
- Read: rd_pulse in cycle k, IDLE, not empty:
  - fifo_rd_en is high in cycle k+2.
  - led_data updates in cycle k+3+RD_LATENCY (k+3 when RD_LATENCY=0).
- Simultaneous wr_pulse and rd_pulse in cycle k:
  - fifo_wr_en is high in cycle k+2.
  - IDLE re-evaluates the read in cycle k+3, using fifo_empty as it is in k+3.
  - fifo_rd_en is high in cycle k+4.
- Minimum spacing between FIFO strobes is 2 cycles.
- ovf_flag and udf_flag rise in the cycle after the rejecting IDLE evaluation.

## Configuration
- FIFO_BTN_REJCNT_EN:
  - Defined: rej_cnt is an 8-bit counter that saturates at 255. It increments once per rejected operation: overflow, underflow, or dropped duplicate pulse. Two rejects in one cycle add 2, still saturating.
  - Undefined: rej_cnt is a constant 0, and no counter logic is synthesized.

## Test plan
- Reset, then wr_pulse with sw_data=0xA5 and fifo_full=0 -> a single fifo_wr_en in cycle k+2 with fifo_wr_data=0xA5; ovf_flag stays 0.
- rd_pulse, fifo_empty=0, RD_LATENCY=1, fifo_rd_data=0x3C -> fifo_rd_en in k+2; led_data=0x3C and led_valid=1 in k+4.
- wr_pulse with fifo_full=1 -> no fifo_wr_en; ovf_flag=1; rej_cnt=1 (macro on). Then clr_flags -> ovf_flag=0 and rej_cnt=0.
- wr_pulse and rd_pulse in the same cycle, FIFO empty before the write and non-empty after it -> fifo_wr_en at k+2, fifo_rd_en at k+4, udf_flag stays 0.
- Two wr_pulses 1 cycle apart, the second with different sw_data -> exactly one write, carrying the first data; rej_cnt=1 (macro on) or 0 (macro off).
- Assert rst in the cycle after rd_pulse -> no fifo_rd_en; all outputs are 0 on the next cycle.
